// File: rtl/mul_defs_pkg.sv
// -----------------------------------------------------------------------------
// mul_defs_pkg
//   Definitions shared by the shift-and-add multiplier:
//     - state_e   : FSM state encodings (IDLE / RUN / DONE; 2'b11 unused)
//     - cnt_width : width of the iteration counter, clog2(BITS+1), wide
//                   enough to hold the value BITS itself.
// -----------------------------------------------------------------------------
package mul_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage : mul_defs_pkg

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
//   Combinational BITS-wide adder with carry in/out.
//   Ports:
//     a, b  [BITS] : operands
//     cin   [1]    : carry in
//     sum   [BITS] : a + b + cin, low BITS bits
//     cout  [1]    : carry out of the MSB
// -----------------------------------------------------------------------------
module adder #(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] sum,
    output logic            cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, cin};

endmodule : adder

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential unsigned BITS x BITS multiplier, radix-2 shift-and-add, one
//   iteration per clock. The external adder forms A + (Q[0] ? M : 0); its
//   carry-out becomes the new MSB when {C,S,Q} is shifted right by one.
//   Ports:
//     clk      [1]      : rising-edge clock
//     rst_n    [1]      : asynchronous active-low reset
//     start    [1]      : request, sampled only in IDLE
//     a        [BITS]   : multiplicand, captured on accepted start
//     b        [BITS]   : multiplier, captured on accepted start
//     busy     [1]      : high while iterating (RUN)
//     done     [1]      : one-cycle pulse, product is new and valid
//     product  [2*BITS] : registered result, updated only on entry to DONE
// -----------------------------------------------------------------------------
module shift_add_multiplier
    import mul_defs_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BITS-1:0]   a,
    input  logic [BITS-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*BITS-1:0] product
);

    localparam int CNT_W = cnt_width(BITS);

    state_e              state_q,   state_d;
    logic [BITS-1:0]     m_q,       m_d;
    logic [BITS-1:0]     acc_q,     acc_d;
    logic [BITS-1:0]     q_q,       q_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [2*BITS-1:0]   product_q, product_d;

    logic [BITS-1:0]     addend;
    logic [BITS-1:0]     sum;
    logic                cout;
    logic [2*BITS-1:0]   shifted;

    // Partial-product add: only add the multiplicand when the current
    // multiplier LSB is set.
    assign addend = q_q[0] ? m_q : '0;

    adder #(
        .BITS (BITS)
    ) u_adder (
        .a    (acc_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // {C,S,Q} right-shifted by one; cout lands in the MSB so the full
    // 2*BITS product stays exact, including (2^BITS-1)^2.
    assign shifted = {cout, sum, q_q[BITS-1:1]};

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no path
        // through the case below leaves one unassigned (which would infer a latch).
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BITS);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                {acc_d, q_d} = shifted;
                cnt_d        = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_DONE;
                    product_d = shifted;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                // Unused encoding: recover to IDLE on the next edge.
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Decoded straight from the state register, so both fall to 0 the instant
    // reset is asserted and the unused encoding drives neither.
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier
//   Directed bench for shift_add_multiplier: a BITS=16 instance for most
//   scenarios and a BITS=4 instance for the small-width maximum case.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [7:0]  product4;

    int checks;
    int errors;

    shift_add_multiplier #(.BITS(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    shift_add_multiplier #(.BITS(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start4),
        .a       (a4),
        .b       (b4),
        .busy    (busy4),
        .done    (done4),
        .product (product4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle and follow the operation to its done pulse.
    // lat counts falling edges from acceptance to done (timeout -> 99),
    // busy_n counts sampled busy cycles, stable is cleared if product moves
    // before done.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          output logic [31:0] res, output int lat,
                          output int busy_n, output bit stable);
        logic [31:0] prev;
        int cyc;
        prev   = product;
        stable = 1'b1;
        busy_n = 0;
        start  = 1'b1;
        a      = ta;
        b      = tb_v;
        @(negedge clk);
        start  = 1'b0;
        a      = 16'h0;
        b      = 16'h0;
        cyc    = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_n++;
            if (product !== prev) stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
        lat = done ? cyc : 99;
        res = product;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = 16'h0;
        b      = 16'h0;
        start4 = 1'b0;
        a4     = 4'h0;
        b4     = 4'h0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (product !== 32'h0) begin errors++; $display("FAIL reset_product: got %h expected 00000000", product); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int lat, bn;
        bit st;
        run_op(16'd3, 16'd5, res, lat, bn, st);
        checks++;
        if (res !== 32'h0000000F) begin errors++; $display("FAIL basic_product: got %h expected 0000000f", res); end
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL basic_latency: got %0d expected 16", lat); end
        checks++;
        if (bn !== 16) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 16", bn); end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: got busy=%b done=%b expected 0/0", busy, done);
        end
        checks++;
        if (product !== 32'h0000000F) begin errors++; $display("FAIL basic_hold: got %h expected 0000000f", product); end
    endtask

    task automatic test_max();
        logic [31:0] res;
        int lat, bn;
        bit st;
        run_op(16'hFFFF, 16'hFFFF, res, lat, bn, st);
        checks++;
        if (res !== 32'hFFFE0001) begin errors++; $display("FAIL max_product: got %h expected fffe0001", res); end
        run_op(16'h8000, 16'h0002, res, lat, bn, st);
        checks++;
        if (res !== 32'h00010000) begin errors++; $display("FAIL msb_product: got %h expected 00010000", res); end
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL msb_latency: got %0d expected 16", lat); end
    endtask

    task automatic test_zero_and_hold();
        logic [31:0] res;
        int lat, bn;
        bit st;
        run_op(16'h0000, 16'h1234, res, lat, bn, st);
        checks++;
        if (res !== 32'h0) begin errors++; $display("FAIL zero_a: got %h expected 00000000", res); end
        checks++;
        if (st !== 1'b1) begin errors++; $display("FAIL hold_before_zero_a: got stable=%b expected 1", st); end
        run_op(16'h1234, 16'h0000, res, lat, bn, st);
        checks++;
        if (res !== 32'h0) begin errors++; $display("FAIL zero_b: got %h expected 00000000", res); end
        run_op(16'h0001, 16'hABCD, res, lat, bn, st);
        checks++;
        if (res !== 32'h0000ABCD) begin errors++; $display("FAIL one_times: got %h expected 0000abcd", res); end
        checks++;
        if (st !== 1'b1) begin errors++; $display("FAIL hold_before_one_times: got stable=%b expected 1", st); end
    endtask

    task automatic test_ignore_start();
        int dones, first_done;
        logic [31:0] res;
        start = 1'b1;
        a     = 16'd7;
        b     = 16'd9;
        @(negedge clk);
        start      = 1'b0;
        dones      = 0;
        first_done = -1;
        res        = 32'hX;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc == 5) begin
                start = 1'b1;
                a     = 16'd2;
                b     = 16'd2;
            end
            if (cyc == 7) begin
                a = 16'h5555;
                b = 16'h00AA;
            end
            if (cyc == 9) start = 1'b0;
            if (done) begin
                dones++;
                if (first_done < 0) begin
                    first_done = cyc;
                    res        = product;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
        checks++;
        if (first_done !== 16) begin errors++; $display("FAIL ignore_latency: got %0d expected 16", first_done); end
        checks++;
        if (res !== 32'd63) begin errors++; $display("FAIL ignore_product: got %0d expected 63", res); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_after: got busy=%b expected 0", busy); end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat, bn, dones;
        bit st;
        start = 1'b1;
        a     = 16'd100;
        b     = 16'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b expected 0", done); end
        checks++;
        if (product !== 32'h0) begin errors++; $display("FAIL areset_product: got %h expected 00000000", product); end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL areset_abort: got %0d active cycles expected 0", dones); end
        run_op(16'd6, 16'd7, res, lat, bn, st);
        checks++;
        if (res !== 32'd42) begin errors++; $display("FAIL areset_next_product: got %0d expected 42", res); end
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL areset_next_latency: got %0d expected 16", lat); end
    endtask

    task automatic test_back_to_back();
        int times[$];
        int wait_cyc;
        start = 1'b1;
        a     = 16'd10;
        b     = 16'd11;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) begin
                times.push_back(i);
                checks++;
                if (product !== 32'd110) begin
                    errors++; $display("FAIL b2b_product: got %0d expected 110", product);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (times.size() !== 3) begin
            errors++; $display("FAIL b2b_pulse_count: got %0d expected 3", times.size());
        end
        for (int i = 1; i < times.size(); i++) begin
            checks++;
            if (times[i] - times[i-1] !== 18) begin
                errors++; $display("FAIL b2b_spacing: got %0d expected 18", times[i] - times[i-1]);
            end
        end
        wait_cyc = 0;
        while ((busy || done) && wait_cyc < 40) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (wait_cyc >= 40) begin errors++; $display("FAIL b2b_drain: got timeout expected idle"); end
        @(negedge clk);
    endtask

    task automatic test_bits4();
        int cyc, bn;
        start4 = 1'b1;
        a4     = 4'hF;
        b4     = 4'hF;
        @(negedge clk);
        start4 = 1'b0;
        cyc    = 0;
        bn     = 0;
        while (!done4 && cyc < 20) begin
            if (busy4) bn++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (product4 !== 8'hE1) begin errors++; $display("FAIL bits4_product: got %h expected e1", product4); end
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL bits4_latency: got %0d expected 4", cyc); end
        checks++;
        if (bn !== 4) begin errors++; $display("FAIL bits4_busy_cycles: got %0d expected 4", bn); end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_max();
        test_zero_and_hold();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        test_bits4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_add_multiplier

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned BITS x BITS multiplier using radix-2 shift-and-add.
- Sits directly upstream of the existing N-bit `adder`. Each cycle it drives the adder's a/b/cin and consumes its sum/cout into the partial-product accumulator.
- Start/busy/done handshake; one iteration per clock; result held until the next accepted start.

Parameters:
- BITS, 16, operand width; product width is 2*BITS; BITS >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  BITS  multiplicand, captured on accepted start
- b  input  BITS  multiplier, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; product valid and new
- product  output  2*BITS  registered result, stable except when updated on entry to DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, product=0, M=0, A=0, Q=0, C=0, cnt=0. Reset mid-RUN aborts the operation; no done pulse is produced; product=0.
- Internal registers: M[BITS] (multiplicand), A[BITS] (accumulator high), Q[BITS] (multiplier/low product), cnt[clog2(BITS+1)].
- Adder hookup:
  - adder.a = A
  - adder.b = Q[0] ? M : 0
  - adder.cin = 0
  - {C,S} = {adder.cout, adder.sum}
- IDLE:
  - busy=0, done=0.
  - start=1 at edge k: M<=a, Q<=b, A<=0, cnt<=BITS, state<=RUN.
  - start=0: remain in IDLE.
- RUN (busy=1):
  - Each edge: {A,Q} <= {C,S,Q[BITS-1:1]}, i.e. a right shift of the (2*BITS+1)-bit {C,S,Q} with cout as the new MSB. cnt<=cnt-1.
  - When cnt==1 on that edge, state<=DONE and product<={C,S,Q[BITS-1:1]}.
  - start, a and b are ignored throughout RUN.
- DONE (one cycle):
  - done=1, busy=0. product is valid.
  - Next edge: state<=IDLE. start is ignored in DONE.
- Latency: start accepted at edge k, done high in the cycle after edge k+BITS, back in IDLE after edge k+BITS+1.
  - Throughput: one product per BITS+2 cycles.
  - start held high continuously gives back-to-back operations with exactly one IDLE cycle between them.
- Width rules:
  - cout is never dropped; it shifts into the MSB of A. The full 2*BITS product is exact, so no overflow is possible.
  - The maximum case (2^BITS-1)^2 must be exact.
- product holds its value through IDLE and RUN of the next operation. It changes only on entry to DONE or on reset.
- Unused state encoding (2'b11) returns to IDLE on the next edge with busy=0, done=0.

Decomposition:
- Shared package/include (mul_defs):
  - state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10
  - macro/function for counter width clog2(BITS+1)
- One sub-module: the existing `adder` instantiated with BITS=BITS. Its cout is consumed and its cin is tied to 0.
- The FSM, shift register and counter live in shift_add_multiplier itself.

Test Plan:
- BITS=16, a=3, b=5, pulse start one cycle -> busy high for 16 cycles, done pulse exactly 16 cycles after acceptance, product=0x0000000F.
- a=0xFFFF, b=0xFFFF -> product=0xFFFE0001 (exercises cout shifting every iteration); a=0x8000, b=0x0002 -> 0x00010000.
- a=0, b=0x1234 and a=0x1234, b=0 -> product=0; then a=1, b=0xABCD -> 0x0000ABCD; product stays at its previous value until each done.
- Start accepted (a=7, b=9); at RUN cycle 5 raise start with a=2, b=2 and change a/b -> ignored, product=63, single done pulse.
- Start with a=100, b=200; assert rst_n=0 asynchronously mid-cycle at RUN cycle 8 -> busy/done/product=0 immediately with no clock edge; after release, IDLE; new start 6x7 -> 42.
- start held high with a=10, b=11 -> done pulses every 18 cycles, product=110 each time; separately, BITS=4, 15x15 -> product=8'hE1 after 4 RUN cycles.
